// File: rtl/taxi_trip_ctrl.sv
// Taxi meter trip controller: sequences a trip, accumulates distance and wait time, and hands off the settled fare.
// Optional build macro NIGHT_RATE_EN adds a night_mode input that raises the base fare and km rate by one yuan.
//
// state      | meaning
// IDLE   (0) | no trip running; outputs hold the last trip's values
// WAIT   (1) | stationary; prescaler accumulates wait seconds
// DRIVE  (2) | moving; wheel pulses add distance
// SETTLE (3) | fare frozen and presented until the consumer accepts it
module taxi_trip_ctrl #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BASE_FARE  = 8,
    parameter int unsigned BASE_UNITS = 30,
    parameter int unsigned KM_RATE    = 2,
    parameter int unsigned MIN_RATE   = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start_pulse,
    input  logic        wait_pulse,
    input  logic        stop_pulse,
    input  logic        wheel_pulse,
`ifdef NIGHT_RATE_EN
    input  logic        night_mode,
`endif
    input  logic        fare_ready,
    output logic [1:0]  trip_state,
    output logic [19:0] dist_100m,
    output logic [19:0] wait_sec,
    output logic [19:0] fare,
    output logic        fare_valid
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DRIVE  = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    localparam logic [19:0] SAT          = 20'hFFFFF;
    localparam logic [31:0] PRE_LAST     = 32'(CLK_FREQ - 1);
    localparam logic [19:0] BASE_UNITS_W = 20'(BASE_UNITS);
    localparam logic [31:0] MIN_RATE_W   = 32'(MIN_RATE);

    state_t      state;
    logic [31:0] prescaler;
    logic [3:0]  km_sub;
    logic [19:0] extra_km;
    logic [5:0]  sec_in_min;
    logic [19:0] wait_min;
    logic [31:0] base_eff;
    logic [31:0] rate_eff;
    logic [31:0] fare_sum;
    logic [19:0] fare_next;
    logic        start_trip;
    logic        dist_inc;
    logic        sec_wrap;
    logic        wait_inc;

`ifdef NIGHT_RATE_EN
    logic night_latched;
    assign base_eff = 32'(BASE_FARE) + {31'd0, night_latched};
    assign rate_eff = 32'(KM_RATE) + {31'd0, night_latched};
`else
    assign base_eff = 32'(BASE_FARE);
    assign rate_eff = 32'(KM_RATE);
`endif

    assign trip_state = state;
    assign start_trip = (state == ST_IDLE) && start_pulse;
    assign dist_inc   = (state == ST_DRIVE) && wheel_pulse && (dist_100m != SAT);
    assign sec_wrap   = (state == ST_WAIT) && (prescaler == PRE_LAST);
    assign wait_inc   = sec_wrap && (wait_sec != SAT);

    // Fare is built from incrementally maintained extra_km / wait_min, so no divider is needed.
    assign fare_sum  = base_eff + rate_eff * {12'd0, extra_km} + MIN_RATE_W * {12'd0, wait_min};
    assign fare_next = (fare_sum > {12'd0, SAT}) ? SAT : fare_sum[19:0];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            dist_100m  <= '0;
            wait_sec   <= '0;
            prescaler  <= '0;
            km_sub     <= '0;
            extra_km   <= '0;
            sec_in_min <= '0;
            wait_min   <= '0;
        end else if (start_trip) begin
            dist_100m  <= '0;
            wait_sec   <= '0;
            prescaler  <= '0;
            km_sub     <= '0;
            extra_km   <= '0;
            sec_in_min <= '0;
            wait_min   <= '0;
        end else begin
            if (dist_inc) begin
                dist_100m <= dist_100m + 20'd1;
                // A started km is charged as soon as its first 100 m beyond the base distance arrives.
                if (dist_100m >= BASE_UNITS_W) begin
                    km_sub <= (km_sub == 4'd9) ? 4'd0 : km_sub + 4'd1;
                    if (km_sub == 4'd0) begin
                        extra_km <= extra_km + 20'd1;
                    end
                end
            end
            // Paused, not cleared, outside WAIT so partial seconds carry across waits.
            if (state == ST_WAIT) begin
                prescaler <= (prescaler == PRE_LAST) ? 32'd0 : prescaler + 32'd1;
            end
            if (wait_inc) begin
                wait_sec   <= wait_sec + 20'd1;
                sec_in_min <= (sec_in_min == 6'd59) ? 6'd0 : sec_in_min + 6'd1;
                if (sec_in_min == 6'd0) begin
                    wait_min <= wait_min + 20'd1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            fare       <= '0;
            fare_valid <= 1'b0;
`ifdef NIGHT_RATE_EN
            night_latched <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_pulse) begin
                        state <= ST_DRIVE;
`ifdef NIGHT_RATE_EN
                        night_latched <= night_mode;
`endif
                    end
                end
                ST_DRIVE: begin
                    fare <= fare_next;
                    if (stop_pulse) begin
                        state      <= ST_SETTLE;
                        fare_valid <= 1'b1;
                    end else if (wait_pulse) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    fare <= fare_next;
                    if (stop_pulse) begin
                        state      <= ST_SETTLE;
                        fare_valid <= 1'b1;
                    end else if (wait_pulse || start_pulse) begin
                        state <= ST_DRIVE;
                    end
                end
                ST_SETTLE: begin
                    if (fare_valid && fare_ready) begin
                        state      <= ST_IDLE;
                        fare_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    fare_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_taxi_trip_ctrl.sv
// Bench for taxi_trip_ctrl: directed trips plus random pulse traffic against an arithmetic fare model.
// Build with NIGHT_RATE_EN defined to also exercise the night tariff.
module tb_taxi_trip_ctrl;

    localparam int CLK  = 10;
    localparam int MAXV = 1048575;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        start_pulse = 1'b0;
    logic        wait_pulse = 1'b0;
    logic        stop_pulse = 1'b0;
    logic        wheel_pulse = 1'b0;
    logic        fare_ready = 1'b0;
`ifdef NIGHT_RATE_EN
    logic        night_mode = 1'b0;
`endif
    logic [1:0]  trip_state;
    logic [19:0] dist_100m;
    logic [19:0] wait_sec;
    logic [19:0] fare;
    logic        fare_valid;

    int checks = 0;
    int failures = 0;

    // Reference model: plain trip quantities, fare derived by ceil arithmetic.
    int m_state = 0;
    int m_dist = 0;
    int m_wcyc = 0;
    int m_fare = 0;
    bit m_valid = 1'b0;
    bit m_night = 1'b0;
    bit night_drv = 1'b0;

    taxi_trip_ctrl #(.CLK_FREQ(CLK)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .start_pulse (start_pulse),
        .wait_pulse  (wait_pulse),
        .stop_pulse  (stop_pulse),
        .wheel_pulse (wheel_pulse),
`ifdef NIGHT_RATE_EN
        .night_mode  (night_mode),
`endif
        .fare_ready  (fare_ready),
        .trip_state  (trip_state),
        .dist_100m   (dist_100m),
        .wait_sec    (wait_sec),
        .fare        (fare),
        .fare_valid  (fare_valid)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic int model_wait_sec();
        int ws;
        ws = m_wcyc / CLK;
        return (ws > MAXV) ? MAXV : ws;
    endfunction

    function automatic int model_fare();
        int ek, wm, f;
        ek = (m_dist > 30) ? (m_dist - 30 + 9) / 10 : 0;
        wm = (model_wait_sec() + 59) / 60;
        f  = 8 + (m_night ? 1 : 0) + (2 + (m_night ? 1 : 0)) * ek + wm;
        return (f > MAXV) ? MAXV : f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_dist = 0; m_wcyc = 0; m_fare = 0; m_valid = 1'b0; m_night = 1'b0;
    endtask

    task automatic model_edge(input bit st, input bit wt, input bit sp, input bit wh, input bit rd, input bit nm);
        int nf;
        nf = (m_state == 1 || m_state == 2) ? model_fare() : m_fare;
        case (m_state)
            0: if (st) begin m_state = 2; m_dist = 0; m_wcyc = 0; m_night = nm; end
            2: begin
                if (wh && m_dist < MAXV) m_dist++;
                if (sp) begin m_state = 3; m_valid = 1'b1; end
                else if (wt) m_state = 1;
            end
            1: begin
                m_wcyc++;
                if (sp) begin m_state = 3; m_valid = 1'b1; end
                else if (wt || st) m_state = 2;
            end
            3: if (rd) begin m_state = 0; m_valid = 1'b0; end
            default: ;
        endcase
        m_fare = nf;
    endtask

    task automatic step(input bit st, input bit wt, input bit sp, input bit wh, input bit rd);
        start_pulse = st; wait_pulse = wt; stop_pulse = sp; wheel_pulse = wh; fare_ready = rd;
`ifdef NIGHT_RATE_EN
        night_mode = night_drv;
`endif
        @(posedge sys_clk);
        model_edge(st, wt, sp, wh, rd, night_drv);
        #1;
        chk("state", 32'(trip_state), m_state);
        chk("dist", 32'(dist_100m), m_dist);
        chk("wait_sec", 32'(wait_sec), model_wait_sec());
        chk("fare", 32'(fare), m_fare);
        chk("valid", 32'(fare_valid), 32'(m_valid));
        start_pulse = 1'b0; wait_pulse = 1'b0; stop_pulse = 1'b0; wheel_pulse = 1'b0; fare_ready = 1'b0;
    endtask

    initial begin
        #2 sys_rst = 1'b1;
        #1;
        chk("rst_state", 32'(trip_state), 0);
        chk("rst_dist", 32'(dist_100m), 0);
        chk("rst_wait", 32'(wait_sec), 0);
        chk("rst_fare", 32'(fare), 0);
        chk("rst_valid", 32'(fare_valid), 0);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // IDLE ignores everything but start
        repeat (3) step(0, 1, 1, 1, 1);
        chk("idle_state", 32'(trip_state), 0);
        chk("idle_dist", 32'(dist_100m), 0);
        chk("idle_fare", 32'(fare), 0);

        // Trip 1: distance tariff boundaries
        step(1, 0, 0, 0, 0);
        repeat (30) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("dist_30", 32'(dist_100m), 30);
        chk("fare_30", 32'(fare), 8);
        step(0, 0, 0, 1, 0);
        chk("fare_31_lat", 32'(fare), 8);
        step(0, 0, 0, 0, 0);
        chk("fare_31", 32'(fare), 10);
        repeat (9) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("dist_40", 32'(dist_100m), 40);
        chk("fare_40", 32'(fare), 10);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("fare_41", 32'(fare), 12);
        step(0, 1, 1, 0, 0);
        chk("stop_prio_state", 32'(trip_state), 3);
        chk("stop_prio_valid", 32'(fare_valid), 1);
        repeat (5) step(1, 1, 1, 1, 0);
        chk("settle_fare", 32'(fare), 12);
        chk("settle_dist", 32'(dist_100m), 41);
        chk("settle_state", 32'(trip_state), 3);
        step(0, 0, 0, 0, 1);
        chk("ack_state", 32'(trip_state), 0);
        chk("ack_valid", 32'(fare_valid), 0);
        chk("ack_fare", 32'(fare), 12);
        repeat (3) step(0, 0, 0, 1, 1);
        chk("idle_keep_dist", 32'(dist_100m), 41);
        chk("idle_keep_fare", 32'(fare), 12);

        // Trip 2: wait tariff, wheel ignored in WAIT
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 600; i++) step(0, 0, 0, (i % 7) == 0, 0);
        chk("wait_60", 32'(wait_sec), 60);
        chk("wait_dist", 32'(dist_100m), 0);
        step(0, 0, 0, 0, 0);
        chk("fare_w60", 32'(fare), 9);
        repeat (9) step(0, 0, 0, 1, 0);
        chk("wait_61", 32'(wait_sec), 61);
        step(0, 0, 0, 0, 0);
        chk("fare_w61", 32'(fare), 10);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("settle2_state", 32'(trip_state), 3);

        // Asynchronous reset in the middle of SETTLE
        @(negedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        chk("mid_rst_state", 32'(trip_state), 0);
        chk("mid_rst_wait", 32'(wait_sec), 0);
        chk("mid_rst_fare", 32'(fare), 0);
        chk("mid_rst_valid", 32'(fare_valid), 0);
        model_reset();
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // Trip 3: partial second carried across waits
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (19) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0);
        chk("carry_wait", 32'(wait_sec), 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("trip3_idle", 32'(trip_state), 0);

`ifdef NIGHT_RATE_EN
        night_drv = 1'b1;
        step(1, 0, 0, 0, 0);
        night_drv = 1'b0;
        repeat (20) step(0, 0, 0, 1, 0);
        night_drv = 1'b1;
        repeat (21) step(0, 0, 0, 1, 0);
        night_drv = 1'b0;
        step(0, 0, 0, 0, 0);
        chk("night_fare", 32'(fare), 15);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
`endif

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
`ifdef NIGHT_RATE_EN
            night_drv = ($urandom_range(0, 1) == 1);
`endif
            step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 1, $urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 30);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
